// File: rtl/alu_seq.sv
// alu_seq - execute-stage sequencer in front of an 8-bit combinational ALU.
//
// Accepts decoded commands over a valid/ready handshake and owns a 4x8-bit
// register file (R0..R3) plus a 4-bit status register {N,V,Z,C}. For
// arithmetic commands it drives the ALU operands/opcode/carry-in for one
// cycle and writes ALU_OUT and the ALU flags back at the end of that cycle.
// ADD16 chains two ALU passes: {R1,R0} += {R3,R2}.
//
// Ports:
//   CLK, RST             clock, asynchronous active-high reset
//   IN_VALID, IN_READY   command handshake (IN_READY high only when idle)
//   CMD, RD, RS, IMM     command code, dest/first operand, source, immediate
//   ALU_OP, ALU_A,
//   ALU_B, ALU_CI        registered ALU drive (zero when not executing)
//   ALU_OUT, ALU_C/Z/N/V combinational ALU result and flags
//   FLAGS                status register {N,V,Z,C}
//   DONE                 one-cycle pulse after a command retires
//   DBG_SEL, DBG_DATA    combinational register-file read port
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready for a command; ALU drive held at zero
// S_EXEC   | single ALU pass (or low byte of ADD16); write back at end
// S_EXEC_HI| high byte of ADD16, carry-in = low-pass carry-out

module alu_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [3:0] CMD,
  input  logic [1:0] RD,
  input  logic [1:0] RS,
  input  logic [7:0] IMM,
  output logic [1:0] ALU_OP,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic       ALU_CI,
  input  logic [7:0] ALU_OUT,
  input  logic       ALU_C,
  input  logic       ALU_Z,
  input  logic       ALU_N,
  input  logic       ALU_V,
  output logic [3:0] FLAGS,
  output logic       DONE,
  input  logic [1:0] DBG_SEL,
  output logic [7:0] DBG_DATA
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_EXEC_HI = 2'd2
  } state_t;

  localparam logic [3:0] CMD_ADC   = 4'd0;
  localparam logic [3:0] CMD_SUB   = 4'd1;
  localparam logic [3:0] CMD_INC   = 4'd2;
  localparam logic [3:0] CMD_DEC   = 4'd3;
  localparam logic [3:0] CMD_ADD16 = 4'd4;
  localparam logic [3:0] CMD_MOV   = 4'd5;
  localparam logic [3:0] CMD_LDI   = 4'd6;
  localparam logic [3:0] CMD_CLC   = 4'd7;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  state_t          state;
  logic [3:0][7:0] regs;
  logic [3:0]      flags;
  logic [3:0]      cmd_q;
  logic [1:0]      rd_q;
  logic [1:0]      rs_q;
  logic [7:0]      imm_q;
  logic            lo_z;
  logic            done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      regs   <= '0;
      flags  <= 4'b0000;
      cmd_q  <= 4'd0;
      rd_q   <= 2'd0;
      rs_q   <= 2'd0;
      imm_q  <= 8'h00;
      lo_z   <= 1'b0;
      done   <= 1'b0;
      ALU_OP <= OP_ADD;
      ALU_A  <= 8'h00;
      ALU_B  <= 8'h00;
      ALU_CI <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            cmd_q <= CMD;
            rd_q  <= RD;
            rs_q  <= RS;
            imm_q <= IMM;
            state <= S_EXEC;
            // Operands are registered here so the ALU sees a clean drive for
            // the whole EXEC cycle; the register file is settled at this
            // point because a previous command has already retired.
            unique case (CMD)
              CMD_ADC: begin
                ALU_OP <= OP_ADD;
                ALU_A  <= regs[RD];
                ALU_B  <= regs[RS];
                ALU_CI <= flags[0];
              end
              CMD_SUB: begin
                ALU_OP <= OP_SUB;
                ALU_A  <= regs[RD];
                ALU_B  <= regs[RS];
                ALU_CI <= 1'b0;
              end
              CMD_INC: begin
                ALU_OP <= OP_INC;
                ALU_A  <= regs[RD];
                ALU_B  <= 8'h00;
                ALU_CI <= 1'b0;
              end
              CMD_DEC: begin
                ALU_OP <= OP_DEC;
                ALU_A  <= regs[RD];
                ALU_B  <= 8'h00;
                ALU_CI <= 1'b0;
              end
              CMD_ADD16: begin
                ALU_OP <= OP_ADD;
                ALU_A  <= regs[0];
                ALU_B  <= regs[2];
                ALU_CI <= 1'b0;
              end
              default: begin
                ALU_OP <= OP_ADD;
                ALU_A  <= 8'h00;
                ALU_B  <= 8'h00;
                ALU_CI <= 1'b0;
              end
            endcase
          end
        end

        S_EXEC: begin
          ALU_OP <= OP_ADD;
          ALU_A  <= 8'h00;
          ALU_B  <= 8'h00;
          ALU_CI <= 1'b0;
          state  <= S_IDLE;
          done   <= 1'b1;
          unique case (cmd_q)
            CMD_ADC, CMD_SUB, CMD_INC, CMD_DEC: begin
              regs[rd_q] <= ALU_OUT;
              flags      <= {ALU_N, ALU_V, ALU_Z, ALU_C};
            end
            CMD_ADD16: begin
              regs[0] <= ALU_OUT;
              lo_z    <= ALU_Z;
              // High pass: the low carry-out is held directly in ALU_CI.
              ALU_OP  <= OP_ADD;
              ALU_A   <= regs[1];
              ALU_B   <= regs[3];
              ALU_CI  <= ALU_C;
              state   <= S_EXEC_HI;
              done    <= 1'b0;
            end
            CMD_MOV: regs[rd_q] <= regs[rs_q];
            CMD_LDI: regs[rd_q] <= imm_q;
            CMD_CLC: flags[0]   <= 1'b0;
            default: ;
          endcase
        end

        S_EXEC_HI: begin
          regs[1] <= ALU_OUT;
          // 16-bit zero needs both bytes zero; N/V/C come from the high byte.
          flags   <= {ALU_N, ALU_V, lo_z & ALU_Z, ALU_C};
          ALU_OP  <= OP_ADD;
          ALU_A   <= 8'h00;
          ALU_B   <= 8'h00;
          ALU_CI  <= 1'b0;
          done    <= 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign IN_READY = (state == S_IDLE);
  assign FLAGS    = flags;
  assign DONE     = done;
  assign DBG_DATA = regs[DBG_SEL];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq - self-checking bench for alu_seq.
// Provides an 8-bit ALU, a behavioural model of the sequencer that predicts
// whole-command results with plain integer arithmetic, a per-cycle compare
// process, directed scenarios with literal expectations and a random phase.

module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] CMD;
  logic [1:0] RD;
  logic [1:0] RS;
  logic [7:0] IMM;
  logic [1:0] ALU_OP;
  logic [7:0] ALU_A;
  logic [7:0] ALU_B;
  logic       ALU_CI;
  logic [7:0] ALU_OUT;
  logic       ALU_C, ALU_Z, ALU_N, ALU_V;
  logic [3:0] FLAGS;
  logic       DONE;
  logic [1:0] DBG_SEL;
  logic [7:0] DBG_DATA;

  int checks   = 0;
  int failures = 0;
  bit dbg_auto = 1'b0;

  always #5 CLK = ~CLK;

  alu_seq dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .CMD(CMD), .RD(RD), .RS(RS), .IMM(IMM),
    .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CI(ALU_CI),
    .ALU_OUT(ALU_OUT), .ALU_C(ALU_C), .ALU_Z(ALU_Z), .ALU_N(ALU_N),
    .ALU_V(ALU_V), .FLAGS(FLAGS), .DONE(DONE),
    .DBG_SEL(DBG_SEL), .DBG_DATA(DBG_DATA)
  );

  // ALU: sub = A + ~B + 1 (C=1 means no borrow), dec = A + 0xFF.
  logic [7:0] alu_bb;
  logic [8:0] alu_s;
  always_comb begin
    alu_bb = ALU_B;
    alu_s  = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_CI};
    case (ALU_OP)
      2'd1: begin alu_bb = ~ALU_B; alu_s = {1'b0, ALU_A} + {1'b0, alu_bb} + 9'd1; end
      2'd2: begin alu_bb = 8'h00;  alu_s = {1'b0, ALU_A} + 9'd1; end
      2'd3: begin alu_bb = 8'hFF;  alu_s = {1'b0, ALU_A} + 9'h0FF; end
      default: ;
    endcase
  end
  assign ALU_OUT = alu_s[7:0];
  assign ALU_C   = alu_s[8];
  assign ALU_Z   = (alu_s[7:0] == 8'h00);
  assign ALU_N   = alu_s[7];
  assign ALU_V   = (ALU_A[7] == alu_bb[7]) && (alu_s[7] != ALU_A[7]);

  // ---------------- behavioural model ----------------
  int         m_reg [4];
  int         m_flags;     // {N,V,Z,C} as bit3..bit0
  int         m_cnt;       // edges left until the accepted command retires
  bit         m_done;
  int         p_reg [4];
  int         p_flags;
  bit         p_add16;
  int         lo_op, lo_a, lo_b, lo_ci, hi_a, hi_b, hi_ci;
  bit         ci_chk;

  function automatic int sx8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int sx16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic int mkflags(input int res, input bit v, input bit c);
    return ((res >= 128) ? 8 : 0) + (v ? 4 : 0) + ((res == 0) ? 2 : 0) + (c ? 1 : 0);
  endfunction

  task automatic predict(input int c, input int d, input int s, input int im);
    int a, b, cy, r, sr, w0, w1, s16, ss;
    a  = m_reg[d];
    b  = m_reg[s];
    cy = m_flags % 2;
    p_reg   = m_reg;
    p_flags = m_flags;
    p_add16 = (c == 4);
    lo_op = 0; lo_a = 0; lo_b = 0; lo_ci = 0; ci_chk = 1'b1;
    hi_a = 0; hi_b = 0; hi_ci = 0;
    case (c)
      0: begin
        r = a + b + cy; sr = sx8(a) + sx8(b) + cy;
        p_reg[d] = r % 256;
        p_flags  = mkflags(r % 256, sr < -128 || sr > 127, r > 255);
        lo_op = 0; lo_a = a; lo_b = b; lo_ci = cy;
      end
      1: begin
        r = (a - b + 256) % 256; sr = sx8(a) - sx8(b);
        p_reg[d] = r;
        p_flags  = mkflags(r, sr < -128 || sr > 127, a >= b);
        lo_op = 1; lo_a = a; lo_b = b;
      end
      2: begin
        r = (a + 1) % 256;
        p_reg[d] = r;
        p_flags  = mkflags(r, a == 127, a == 255);
        lo_op = 2; lo_a = a; ci_chk = 1'b0;
      end
      3: begin
        r = (a + 255) % 256;
        p_reg[d] = r;
        p_flags  = mkflags(r, a == 128, a != 0);
        lo_op = 3; lo_a = a; ci_chk = 1'b0;
      end
      4: begin
        w0  = m_reg[1] * 256 + m_reg[0];
        w1  = m_reg[3] * 256 + m_reg[2];
        s16 = w0 + w1;
        ss  = sx16(w0) + sx16(w1);
        p_reg[0] = s16 % 256;
        p_reg[1] = (s16 / 256) % 256;
        p_flags  = ((p_reg[1] >= 128) ? 8 : 0) + ((ss < -32768 || ss > 32767) ? 4 : 0)
                 + (((s16 % 65536) == 0) ? 2 : 0) + ((s16 > 65535) ? 1 : 0);
        lo_op = 0; lo_a = m_reg[0]; lo_b = m_reg[2]; lo_ci = 0;
        hi_a = m_reg[1]; hi_b = m_reg[3]; hi_ci = (m_reg[0] + m_reg[2] > 255) ? 1 : 0;
      end
      5: p_reg[d] = b;
      6: p_reg[d] = im;
      7: p_flags = m_flags - cy;
      default: ;
    endcase
  endtask

  initial begin
    m_cnt = 0; m_done = 1'b0; m_flags = 0; p_add16 = 1'b0;
    for (int i = 0; i < 4; i++) begin m_reg[i] = 0; p_reg[i] = 0; end
    forever begin
      @(posedge CLK or posedge RST);
      if (RST === 1'b1) begin
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_flags = 0; m_cnt = 0; m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 1) m_reg[0] = p_reg[0];  // ADD16 low byte lands one edge early
          if (m_cnt == 0) begin
            m_reg   = p_reg;
            m_flags = p_flags;
            m_done  = 1'b1;
          end
        end else if (IN_VALID === 1'b1) begin
          predict(int'(CMD), int'(RD), int'(RS), int'(IMM));
          m_cnt = p_add16 ? 2 : 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  initial forever begin
    int eo, ea, eb, ec;
    bit echk;
    @(negedge CLK);
    if (RST === 1'b0) begin
      eo = 0; ea = 0; eb = 0; ec = 0; echk = 1'b1;
      if (m_cnt > 0) begin
        if (p_add16 && m_cnt == 1) begin
          ea = hi_a; eb = hi_b; ec = hi_ci;
        end else begin
          eo = lo_op; ea = lo_a; eb = lo_b; ec = lo_ci; echk = ci_chk;
        end
      end
      chk("in_ready", 16'(IN_READY), 16'(m_cnt == 0));
      chk("done",     16'(DONE),     16'(m_done));
      chk("flags",    16'(FLAGS),    16'(m_flags));
      chk("dbg_data", 16'(DBG_DATA), 16'(m_reg[DBG_SEL]));
      chk("alu_op",   16'(ALU_OP),   16'(eo));
      chk("alu_a",    16'(ALU_A),    16'(ea));
      chk("alu_b",    16'(ALU_B),    16'(eb));
      if (echk) chk("alu_ci", 16'(ALU_CI), 16'(ec));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
    if (dbg_auto) DBG_SEL = 2'($urandom_range(0, 3));
  endtask

  task automatic send(input int c, input int d, input int s, input int im, input bit hold);
    while (m_cnt != 0) tick();
    CMD = 4'(c); RD = 2'(d); RS = 2'(s); IMM = 8'(im);
    IN_VALID = 1'b1;
    tick();
    if (hold) tick();
    IN_VALID = 1'b0;
  endtask

  task automatic finish_cmd();
    while (m_cnt != 0) tick();
  endtask

  task automatic peek(input int idx, input int exp, input string nm);
    DBG_SEL = 2'(idx);
    #1;
    chk(nm, 16'(DBG_DATA), 16'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; CMD = 4'd0; RD = 2'd0; RS = 2'd0; IMM = 8'h00; DBG_SEL = 2'd0;
    #12;
    chk("rst_in_ready", 16'(IN_READY), 16'd1);
    chk("rst_done",     16'(DONE),     16'd0);
    chk("rst_flags",    16'(FLAGS),    16'd0);
    chk("rst_alu_a",    16'(ALU_A),    16'd0);
    chk("rst_dbg",      16'(DBG_DATA), 16'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // LDI R0=7F, LDI R1=01, SUB R0,R0
    send(6, 0, 0, 'h7F, 1'b0); finish_cmd();
    chk("ldi_done_cycle2", 16'(DONE), 16'd1);
    send(6, 1, 0, 'h01, 1'b0); finish_cmd();
    send(1, 0, 0, 0, 1'b0);    finish_cmd();
    chk("sub_done_cycle2", 16'(DONE), 16'd1);
    peek(0, 'h00, "sub_r0");
    chk("sub_z", 16'(FLAGS[1]), 16'd1);
    tick();
    chk("sub_done_once", 16'(DONE), 16'd0);

    // LDI R2=7F, LDI R3=01, CLC, ADC R2,R3
    send(6, 2, 0, 'h7F, 1'b0); finish_cmd();
    send(6, 3, 0, 'h01, 1'b0); finish_cmd();
    send(7, 0, 0, 0, 1'b0);    finish_cmd();
    send(0, 2, 3, 0, 1'b0);
    chk("adc_exec_ci", 16'(ALU_CI), 16'd0);
    chk("adc_exec_a",  16'(ALU_A),  16'h7F);
    finish_cmd();
    peek(2, 'h80, "adc_r2");
    chk("adc_nvz", 16'(FLAGS[3:1]), 16'b110);

    // ADD16 0x00FF + 0x0001
    send(6, 0, 0, 'hFF, 1'b0); finish_cmd();
    send(6, 1, 0, 'h00, 1'b0); finish_cmd();
    send(6, 2, 0, 'h01, 1'b0); finish_cmd();
    send(6, 3, 0, 'h00, 1'b0); finish_cmd();
    send(4, 0, 0, 0, 1'b0);
    chk("add16_lo_a", 16'(ALU_A), 16'hFF);
    tick();
    chk("add16_hi_ci", 16'(ALU_CI), 16'd1);
    chk("add16_hi_done", 16'(DONE), 16'd0);
    finish_cmd();
    chk("add16_done_cycle3", 16'(DONE), 16'd1);
    peek(0, 'h00, "add16_r0");
    peek(1, 'h01, "add16_r1");
    chk("add16_zc", 16'(FLAGS[1:0]), 16'b00);

    // ADD16 0xFFFF + 0x0001
    send(6, 0, 0, 'hFF, 1'b0); finish_cmd();
    send(6, 1, 0, 'hFF, 1'b0); finish_cmd();
    send(4, 0, 0, 0, 1'b0);    finish_cmd();
    peek(0, 'h00, "add16b_r0");
    peek(1, 'h00, "add16b_r1");
    chk("add16b_zc", 16'(FLAGS[1:0]), 16'b11);

    // INC R1 with IN_VALID held while busy
    CMD = 4'd2; RD = 2'd1; RS = 2'd0; IN_VALID = 1'b1;
    tick();
    chk("hold_ready_low", 16'(IN_READY), 16'd0);
    tick();
    IN_VALID = 1'b0;
    chk("hold_done", 16'(DONE), 16'd1);
    tick();
    chk("hold_no_second", 16'(DONE), 16'd0);
    peek(1, 'h01, "hold_inc_r1");

    // DEC on 0x00
    send(3, 0, 0, 0, 1'b0); finish_cmd();
    peek(0, 'hFF, "dec_r0");
    chk("dec_n", 16'(FLAGS[3]), 16'd1);

    // Reset during EXEC_HI of ADD16
    send(6, 2, 0, 'h05, 1'b0); finish_cmd();
    send(6, 3, 0, 'h07, 1'b0); finish_cmd();
    send(4, 0, 0, 0, 1'b0);
    tick();
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_ready", 16'(IN_READY), 16'd1);
    chk("mid_rst_done",  16'(DONE),     16'd0);
    chk("mid_rst_flags", 16'(FLAGS),    16'd0);
    chk("mid_rst_ci",    16'(ALU_CI),   16'd0);
    for (int i = 0; i < 4; i++) peek(i, 0, "mid_rst_reg");
    @(posedge CLK); #1;
    RST = 1'b0;
    send(5, 3, 0, 0, 1'b0); finish_cmd();
    peek(3, 'h00, "mov_r3");
    chk("mov_flags", 16'(FLAGS), 16'd0);

    // Random phase
    dbg_auto = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int c;
      c = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) c = 6;
      if ($urandom_range(0, 5) == 0) c = 4;
      repeat ($urandom_range(0, 2)) tick();
      send(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
    end
    finish_cmd();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
